sim_mem_mp: RTL and testbench

SIM_MEM_MP -- requirements
Module: sim_mem_mp

---
 rtl/sim_mem_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 24 ++
 rtl/sim_mem_mp.sv | 181 ++++++++++++++++++
 tb/tb_sim_mem_mp.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_mem_pkg.sv
// Shared encodings and helpers for the multi-port simulation memory.
package sim_mem_pkg;

    // Access size encodings carried on the width port.
    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;
    localparam logic [1:0] W_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    // Bytes touched relative to the start byte; illegal width touches none.
    function automatic logic [3:0] lane_mask(input logic [1:0] w);
        case (w)
            W_BYTE:  return 4'b0001;
            W_HALF:  return 4'b0011;
            W_WORD:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requesting port at or after the pointer.
module rr_arbiter #(
    parameter int NPORT = 2,
    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic [NPORT-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    gnt_idx,
    output logic             gnt_vld
);

    // Scan ports starting from ptr, wrapping once; first hit wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            if (!gnt_vld && req[(int'(ptr) + i) % NPORT]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'((int'(ptr) + i) % NPORT);
            end
        end
    end

endmodule

// File: rtl/sim_mem_mp.sv
// Multi-port behavioural halfword memory with round-robin access,
// byte/halfword/word accesses at any byte address, and bounds checking.
module sim_mem_mp
    import sim_mem_pkg::*;
#(
    parameter int NPORT        = 2,
    parameter int DEPTH        = 65536,
    parameter int ADDR_W       = 24,
    parameter int LAT          = 2,
    parameter int INIT_CYCLES  = 192,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                    clk25m,
    input  logic                    rst,
    input  logic [NPORT-1:0]        req,
    input  logic [NPORT*ADDR_W-1:0] addr,
    input  logic [NPORT-1:0]        odd,
    input  logic [NPORT-1:0]        we,
    input  logic [NPORT*32-1:0]     wdata,
    input  logic [NPORT*2-1:0]      width,
    output logic [NPORT*32-1:0]     rdata,
    output logic [NPORT-1:0]        ack,
    output logic [NPORT-1:0]        err,
    output logic                    init_done
);

    localparam int PW     = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int AW_MEM = $clog2(DEPTH);
    localparam int BW     = ADDR_W + 2;
    localparam logic [BW-1:0] MEM_BYTES = BW'(2 * DEPTH);

    state_e                  state_q, state_d;
    logic [15:0]             init_cnt_q, init_cnt_d;
    logic [3:0]              busy_cnt_q, busy_cnt_d;
    logic [PW-1:0]           gnt_q, gnt_d, ptr_q, ptr_d;
    logic [ADDR_W:0]         badr_q, badr_d;
    logic                    we_q, we_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [1:0]              width_q, width_d;
    logic [NPORT-1:0]        ack_q, ack_d, err_q, err_d;
    logic [NPORT-1:0][31:0]  rdata_q, rdata_d;

    logic [PW-1:0]           arb_idx;
    logic                    arb_vld;
    logic [3:0]              mask;
    logic [BW-1:0]           last_b;
    logic                    acc_err;
    logic [3:0][BW-1:0]      lane_b;
    logic [3:0][AW_MEM-1:0]  lane_hw;
    logic [3:0]              lane_hi;
    logic [3:0]              lane_en;
    logic [31:0]             rd_word;
    logic                    do_wr;

    logic [15:0]             mem [DEPTH];

    rr_arbiter #(.NPORT(NPORT)) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // Map the captured access onto byte lanes and assemble read data.
    always_comb begin
        mask    = lane_mask(width_q);
        last_b  = BW'(badr_q) + BW'({mask[3], mask[1]});
        acc_err = (width_q == W_ILL) || (last_b >= MEM_BYTES);
        rd_word = '0;
        lane_b  = '0;
        lane_hw = '0;
        lane_hi = '0;
        lane_en = '0;
        for (int i = 0; i < 4; i++) begin
            lane_b[i]  = BW'(badr_q) + BW'(i);
            lane_hw[i] = AW_MEM'(lane_b[i] >> 1);
            lane_hi[i] = lane_b[i][0];
            lane_en[i] = mask[i] && !acc_err;
            if (lane_en[i])
                rd_word[8*i +: 8] = mem[lane_hw[i]][{lane_hi[i], 3'b000} +: 8];
        end
    end

    // Sequencer: init delay, grant/capture, access wait, completion pulse.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        busy_cnt_d = busy_cnt_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        badr_d     = badr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        width_d    = width_q;
        ack_d      = '0;
        err_d      = '0;
        rdata_d    = rdata_q;
        do_wr      = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == 16'(INIT_CYCLES - 1)) state_d = ST_IDLE;
                else init_cnt_d = init_cnt_q + 16'd1;
            end
            ST_IDLE: begin
                if (arb_vld) begin
                    state_d    = ST_BUSY;
                    busy_cnt_d = '0;
                    gnt_d      = arb_idx;
                    ptr_d      = (arb_idx == PW'(NPORT - 1)) ? '0 : arb_idx + 1'b1;
                    badr_d     = {addr[arb_idx*ADDR_W +: ADDR_W], odd[arb_idx]};
                    we_d       = we[arb_idx];
                    wdata_d    = wdata[arb_idx*32 +: 32];
                    width_d    = width[arb_idx*2 +: 2];
                end
            end
            ST_BUSY: begin
                // One capture cycle plus LAT access cycles before completion.
                if (busy_cnt_q == 4'(LAT)) begin
                    state_d        = ST_DONE;
                    ack_d[gnt_q]   = 1'b1;
                    err_d[gnt_q]   = acc_err;
                    do_wr          = we_q && !acc_err;
                    if (!we_q && !acc_err) rdata_d[gnt_q] = rd_word;
                end else begin
                    busy_cnt_d = busy_cnt_q + 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase
    end

    // Control and result registers; reset wins over everything.
    always_ff @(posedge clk25m) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            busy_cnt_q <= '0;
            gnt_q      <= '0;
            ptr_q      <= '0;
            badr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            width_q    <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            busy_cnt_q <= busy_cnt_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            badr_q     <= badr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            width_q    <= width_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    // Storage: optional clear on reset, otherwise commit touched bytes only.
    always_ff @(posedge clk25m) begin
        if (rst) begin
            if (CLEAR_ON_RST != 0)
                for (int i = 0; i < DEPTH; i++) mem[AW_MEM'(i)] <= '0;
        end else if (do_wr) begin
            for (int i = 0; i < 4; i++)
                if (lane_en[i])
                    mem[lane_hw[i]][{lane_hi[i], 3'b000} +: 8] <= wdata_q[8*i +: 8];
        end
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign init_done = (state_q != ST_INIT);

endmodule

// File: tb/tb_sim_mem_mp.sv
// Bench for sim_mem_mp: vector table through a scoreboard, plus init,
// contention, dropped-request and reset-abort sequences.
module tb_sim_mem_mp;
    import sim_mem_pkg::*;

    localparam int NPORT = 2;
    localparam int DEPTH = 65536;
    localparam int ADDR_W = 24;
    localparam int LAT = 2;
    localparam int INIT_CYCLES = 192;

    logic        clk25m = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [47:0] addr = '0;
    logic [1:0]  odd = '0;
    logic [1:0]  we = '0;
    logic [63:0] wdata = '0;
    logic [3:0]  width = '0;
    logic [63:0] rdata;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic        init_done;

    sim_mem_mp #(
        .NPORT(NPORT), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LAT(LAT),
        .INIT_CYCLES(INIT_CYCLES), .CLEAR_ON_RST(1)
    ) dut (
        .clk25m(clk25m), .rst(rst), .req(req), .addr(addr), .odd(odd),
        .we(we), .wdata(wdata), .width(width), .rdata(rdata), .ack(ack),
        .err(err), .init_done(init_done)
    );

    always #20 clk25m = ~clk25m;

    int cyc = 0;
    always @(posedge clk25m) cyc <= cyc + 1;

    typedef struct {
        int          port;
        bit          we;
        logic [23:0] addr;
        bit          odd;
        logic [1:0]  width;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct {
        int          port;
        bit          err;
        logic [31:0] rd;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] last_rd [2];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and retire any acks against the queue.
    task automatic tick();
        exp_t e;
        @(negedge clk25m);
        for (int p = 0; p < 2; p++) begin
            if (ack[p]) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL spurious_ack: port %0d acked at cycle %0d with nothing expected", p, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("ack_port", 32'(p), 32'(e.port));
                    chk("err", 32'(err[p]), 32'(e.err));
                    chk("rdata", rdata[p*32 +: 32], e.rd);
                end
            end
        end
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        addr[v.port*24 +: 24] = v.addr;
        odd[v.port]           = v.odd;
        we[v.port]            = v.we;
        wdata[v.port*32 +: 32] = v.wdata;
        width[v.port*2 +: 2]  = v.width;
        req[v.port]           = 1'b1;
        e.port = v.port;
        e.err  = v.exp_err;
        e.rd   = (!v.we && !v.exp_err) ? v.exp_rd : last_rd[v.port];
        last_rd[v.port] = e.rd;
        sbq.push_back(e);
    endtask

    task automatic wait_ack(input int p, input int t0, input string name);
        bit got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            if (ack[p]) got = 1'b1;
        end
        req[p] = 1'b0;
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: no ack on port %0d within 40 cycles", name, p);
        end else begin
            chk({name, "_lat"}, 32'(cyc - t0), 32'(LAT + 2));
        end
    endtask

    task automatic do_access(input vec_t v, input string name);
        int t0;
        tick();
        drive(v);
        t0 = cyc;
        wait_ack(v.port, t0, name);
    endtask

    task automatic wait_init(input string name);
        int r = cyc;
        for (int k = 0; k < 300 && !init_done; k++) tick();
        chk(name, 32'(cyc - r), 32'(INIT_CYCLES));
    endtask

    vec_t tv [19];
    vec_t hv;
    int   acyc [4];
    int   na;
    int   t0;

    initial begin
        tv[0]  = '{0, 1, 24'h10,     0, W_WORD, 32'hDDCCBBAA, 0, 32'h0};
        tv[1]  = '{0, 1, 24'h10,     1, W_BYTE, 32'h00000055, 0, 32'h0};
        tv[2]  = '{0, 0, 24'h10,     0, W_WORD, 32'h0,        0, 32'hDDCC55AA};
        tv[3]  = '{1, 1, 24'h20,     1, W_WORD, 32'h44332211, 0, 32'h0};
        tv[4]  = '{1, 0, 24'h21,     0, W_HALF, 32'h0,        0, 32'h00003322};
        tv[5]  = '{1, 0, 24'h21,     1, W_HALF, 32'h0,        0, 32'h00004433};
        tv[6]  = '{0, 0, 24'h20,     0, W_BYTE, 32'h0,        0, 32'h00000000};
        tv[7]  = '{0, 0, 24'h20,     1, W_BYTE, 32'h0,        0, 32'h00000011};
        tv[8]  = '{1, 0, 24'h20,     1, W_WORD, 32'h0,        0, 32'h44332211};
        tv[9]  = '{0, 1, 24'hFFFF,   0, W_WORD, 32'hFFFFFFFF, 1, 32'h0};
        tv[10] = '{0, 0, 24'hFFFF,   0, W_HALF, 32'h0,        0, 32'h00000000};
        tv[11] = '{1, 0, 24'h10,     0, W_ILL,  32'h0,        1, 32'h0};
        tv[12] = '{0, 0, 24'hFFFF,   1, W_HALF, 32'h0,        1, 32'h0};
        tv[13] = '{0, 0, 24'hFFFF,   1, W_BYTE, 32'h0,        0, 32'h00000000};
        tv[14] = '{0, 1, 24'h30,     1, W_HALF, 32'hFFFFBEEF, 0, 32'h0};
        tv[15] = '{0, 0, 24'h30,     0, W_WORD, 32'h0,        0, 32'h00BEEF00};
        tv[16] = '{0, 1, 24'h40,     0, W_BYTE, 32'h12345678, 0, 32'h0};
        tv[17] = '{1, 0, 24'h40,     0, W_HALF, 32'h0,        0, 32'h00000078};
        tv[18] = '{1, 0, 24'h100000, 0, W_BYTE, 32'h0,        1, 32'h0};
        last_rd[0] = '0;
        last_rd[1] = '0;

        // Reset values, then init delay with port 0 already requesting.
        req[0] = 1'b1;
        width[1:0] = W_WORD;
        tick(); tick(); tick();
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_rdata0", rdata[31:0], 32'h0);
        chk("rst_rdata1", rdata[63:32], 32'h0);
        chk("rst_init_done", 32'(init_done), 32'h0);
        rst = 1'b0;
        wait_init("init_rise");
        sbq.push_back('{0, 1'b0, 32'h0});
        t0 = cyc;
        wait_ack(0, t0, "first_read");

        for (int i = 0; i < 19; i++) do_access(tv[i], $sformatf("vec%0d", i));

        // Both ports held: alternating grants starting at port 0.
        tick();
        hv = '{0, 0, 24'h10, 0, W_WORD, 32'h0, 0, 32'hDDCC55AA};
        drive(hv);
        hv = '{1, 0, 24'h20, 1, W_WORD, 32'h0, 0, 32'h44332211};
        drive(hv);
        sbq.push_back('{0, 1'b0, 32'hDDCC55AA});
        sbq.push_back('{1, 1'b0, 32'h44332211});
        t0 = cyc;
        na = 0;
        for (int k = 0; k < 60 && na < 4; k++) begin
            tick();
            if (ack != 2'b00) begin
                acyc[na] = cyc;
                na++;
            end
        end
        req = '0;
        if (na < 4) begin
            n_vec++;
            n_bad++;
            $display("FAIL rr_timeout: saw %0d acks, needed 4", na);
        end else begin
            chk("rr_first_lat", 32'(acyc[0] - t0), 32'(LAT + 2));
            for (int i = 1; i < 4; i++) chk("rr_period", 32'(acyc[i] - acyc[i-1]), 32'(LAT + 3));
        end

        // Requester lets go and changes inputs after the grant edge.
        tick();
        hv = '{0, 1, 24'h50, 0, W_WORD, 32'hCAFEF00D, 0, 32'h0};
        drive(hv);
        t0 = cyc;
        tick();
        req[0] = 1'b0;
        addr[23:0] = 24'h60;
        wdata[31:0] = 32'h0;
        width[1:0] = W_BYTE;
        wait_ack(0, t0, "dropped_req");
        do_access('{0, 0, 24'h50, 0, W_WORD, 32'h0, 0, 32'hCAFEF00D}, "raw_50");
        do_access('{1, 0, 24'h60, 0, W_WORD, 32'h0, 0, 32'h00000000}, "untouched_60");

        // Reset while a write is in flight: no ack, no commit.
        tick();
        addr[23:0] = 24'h30;
        odd[0] = 1'b0;
        we[0] = 1'b1;
        wdata[31:0] = 32'hAAAAAAAA;
        width[1:0] = W_WORD;
        req[0] = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        chk("rst2_ack", 32'(ack), 32'h0);
        chk("rst2_init_done", 32'(init_done), 32'h0);
        chk("rst2_rdata1", rdata[63:32], 32'h0);
        rst = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        wait_init("init_rise2");
        do_access('{0, 0, 24'h30, 0, W_WORD, 32'h0, 0, 32'h00000000}, "abort_30");
        do_access('{1, 0, 24'h10, 0, W_WORD, 32'h0, 0, 32'h00000000}, "cleared_10");
        chk("sb_empty", 32'(sbq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
